// File: rtl/ram_sp_be.sv
// Single-port RAM with per-byte write enables, registered read + valid strobe and range check.
// Optional power-on/requested zero sweep compiled in with RAM_CLEAR_EN.
//   state | meaning
//   IDLE  | serving read/write requests
//   CLEAR | writing zero to mem[ClrAddr], requests ignored (RAM_CLEAR_EN only)
module ram_sp_be #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic                    WriteEn,
    input  logic                    ReadEn,
    input  logic                    ClearReq,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    ReadValid,
    output logic                    AddrErr,
    output logic                    Busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] depthV = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  serve;
    logic                  inRange;
    logic                  wrEn;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [NB-1:0]         wrMask;
    logic [DATA_WIDTH-1:0] wrData;

    assign inRange = ({1'b0, Address} < depthV);

`ifdef RAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [ADDR_WIDTH-1:0] lastAddr = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ClrAddr;

    // A clear request takes priority over any request presented in the same cycle.
    assign serve = (state == IDLE) && !ClearReq;
    assign Busy  = (state == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            ClrAddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ClearReq) begin
                        state   <= CLEAR;
                        ClrAddr <= '0;
                    end
                end
                CLEAR: begin
                    if (ClrAddr == lastAddr) begin
                        state   <= IDLE;
                        ClrAddr <= '0;
                    end else begin
                        ClrAddr <= ClrAddr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign serve = 1'b1;
    // No sweep in this build: ClearReq has no effect and Busy is constant low.
    assign Busy  = 1'b0 & ClearReq;
`endif

    always_comb begin
        wrEn   = serve && WriteEn && inRange;
        wrAddr = Address;
        wrMask = ByteEn;
        wrData = WriteData;
`ifdef RAM_CLEAR_EN
        if (state == CLEAR) begin
            wrEn   = 1'b1;
            wrAddr = ClrAddr;
            wrMask = '1;
            wrData = '0;
        end
`endif
    end

    // Array has no reset; contents only change through writes or the sweep.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < NB; i++) begin
                if (wrMask[i]) mem[wrAddr][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
    end

    // Read-first: the nonblocking array update lands after this read samples mem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData  <= '0;
            ReadValid <= 1'b0;
            AddrErr   <= 1'b0;
        end else begin
            ReadValid <= serve && ReadEn;
            AddrErr   <= serve && (WriteEn || ReadEn) && !inRange;
            if (serve && ReadEn) ReadData <= inRange ? mem[Address] : '0;
        end
    end

endmodule

// File: tb/tb_ram_sp_be.sv
// Directed self-checking bench for ram_sp_be: 8-bit/1024, 32-bit/16 and 8-bit/1000 instances.
// Clear-sweep expectations follow RAM_CLEAR_EN.
module tb_ram_sp_be;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

`ifdef RAM_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [9:0]  aAddr;
    logic [7:0]  aWd;
    logic [0:0]  aBe;
    logic        aWe, aRe, aClr;
    logic [7:0]  aRd;
    logic        aRv, aErr, aBusy;

    logic [3:0]  bAddr;
    logic [31:0] bWd;
    logic [3:0]  bBe;
    logic        bWe, bRe, bClr;
    logic [31:0] bRd;
    logic        bRv, bErr, bBusy;

    logic [9:0]  cAddr;
    logic [7:0]  cWd;
    logic [0:0]  cBe;
    logic        cWe, cRe, cClr;
    logic [7:0]  cRd;
    logic        cRv, cErr, cBusy;

    ram_sp_be #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(1024)) dutA (
        .clk(clk), .rst_n(rst_n), .Address(aAddr), .WriteData(aWd), .ByteEn(aBe),
        .WriteEn(aWe), .ReadEn(aRe), .ClearReq(aClr),
        .ReadData(aRd), .ReadValid(aRv), .AddrErr(aErr), .Busy(aBusy));

    ram_sp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16)) dutB (
        .clk(clk), .rst_n(rst_n), .Address(bAddr), .WriteData(bWd), .ByteEn(bBe),
        .WriteEn(bWe), .ReadEn(bRe), .ClearReq(bClr),
        .ReadData(bRd), .ReadValid(bRv), .AddrErr(bErr), .Busy(bBusy));

    ram_sp_be #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(1000)) dutC (
        .clk(clk), .rst_n(rst_n), .Address(cAddr), .WriteData(cWd), .ByteEn(cBe),
        .WriteEn(cWe), .ReadEn(cRe), .ClearReq(cClr),
        .ReadData(cRd), .ReadValid(cRv), .AddrErr(cErr), .Busy(cBusy));

    task automatic opA(input logic we, input logic re, input logic clr,
                       input logic [9:0] addr, input logic [7:0] d);
        aWe = we; aRe = re; aClr = clr; aAddr = addr; aWd = d; aBe = 1'b1;
        @(posedge clk); #1;
        aWe = 1'b0; aRe = 1'b0; aClr = 1'b0;
    endtask

    task automatic opB(input logic we, input logic re, input logic [3:0] addr,
                       input logic [31:0] d, input logic [3:0] be);
        bWe = we; bRe = re; bAddr = addr; bWd = d; bBe = be;
        @(posedge clk); #1;
        bWe = 1'b0; bRe = 1'b0;
    endtask

    task automatic opC(input logic we, input logic re, input logic [9:0] addr, input logic [7:0] d);
        cWe = we; cRe = re; cAddr = addr; cWd = d; cBe = 1'b1;
        @(posedge clk); #1;
        cWe = 1'b0; cRe = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((aBusy || bBusy || cBusy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 3000) begin bad++; $display("FAIL wait_idle timed out after %0d cycles", n); end
    endtask

    task automatic countBusy(input string name);
        int n = 0;
        while (aBusy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== 1024) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=1024", name, n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (aRd !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", aRd); end
        total++; if (aRv !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b exp=0", aRv); end
        total++; if (aErr !== 1'b0) begin bad++; $display("FAIL rst_adderr got=%0b exp=0", aErr); end
        total++; if (aBusy !== EXP_BUSY) begin bad++; $display("FAIL rst_busy got=%0b exp=%0b", aBusy, EXP_BUSY); end
        rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
        countBusy("post_reset");
`else
        @(posedge clk); #1;
        total++; if (aBusy !== 1'b0) begin bad++; $display("FAIL busy_after_rst got=%0b exp=0", aBusy); end
`endif
        waitIdle();
    endtask

`ifdef RAM_CLEAR_EN
    task automatic test_clear_reads();
        logic [9:0] ad [3] = '{10'd0, 10'd131, 10'd1023};
        opA(1'b1, 1'b0, 1'b0, 10'd500, 8'h5A);
        opA(1'b0, 1'b1, 1'b0, 10'd500, 8'h00);
        for (int i = 0; i < 3; i++) begin
            opA(1'b0, 1'b1, 1'b0, ad[i], 8'h00);
            total++; if (aRv !== 1'b1) begin bad++; $display("FAIL swept_rvalid@%0d got=%0b exp=1", ad[i], aRv); end
            total++; if (aRd !== 8'h00) begin bad++; $display("FAIL swept_rdata@%0d got=%0h exp=0", ad[i], aRd); end
        end
    endtask
`endif

    task automatic test_basic();
        logic [9:0] ad [3] = '{10'd131, 10'd21, 10'd10};
        logic [7:0] dv [3] = '{8'd39, 8'd84, 8'd95};
        for (int i = 0; i < 3; i++) begin
            opA(1'b1, 1'b0, 1'b0, ad[i], dv[i]);
            total++; if (aRv !== 1'b0) begin bad++; $display("FAIL write_rvalid@%0d got=%0b exp=0", ad[i], aRv); end
        end
        for (int i = 0; i < 3; i++) begin
            opA(1'b0, 1'b1, 1'b0, ad[i], 8'h00);
            total++; if (aRv !== 1'b1) begin bad++; $display("FAIL read_rvalid@%0d got=%0b exp=1", ad[i], aRv); end
            total++; if (aRd !== dv[i]) begin bad++; $display("FAIL read_data@%0d got=%0d exp=%0d", ad[i], aRd, dv[i]); end
        end
        @(posedge clk); #1;
        total++; if (aRv !== 1'b0) begin bad++; $display("FAIL rvalid_drop got=%0b exp=0", aRv); end
        total++; if (aRd !== 8'd95) begin bad++; $display("FAIL rdata_hold got=%0d exp=95", aRd); end
    endtask

    task automatic test_byte_en();
        opB(1'b1, 1'b0, 4'd5, 32'hAABBCCDD, 4'b1111);
        opB(1'b1, 1'b0, 4'd5, 32'h11223344, 4'b0101);
        opB(1'b0, 1'b1, 4'd5, 32'h0, 4'b0000);
        total++; if (bRd !== 32'hAA22CC44) begin bad++; $display("FAIL be_merge got=%h exp=aa22cc44", bRd); end
        total++; if (bRv !== 1'b1) begin bad++; $display("FAIL be_rvalid got=%0b exp=1", bRv); end
        opB(1'b1, 1'b0, 4'd5, 32'hFFFFFFFF, 4'b0000);
        opB(1'b1, 1'b0, 4'd6, 32'h12345678, 4'b1000);
        opB(1'b0, 1'b1, 4'd5, 32'h0, 4'b0000);
        total++; if (bRd !== 32'hAA22CC44) begin bad++; $display("FAIL be_zero got=%h exp=aa22cc44", bRd); end
        opB(1'b1, 1'b0, 4'd6, 32'hCAFEF00D, 4'b0110);
        opB(1'b0, 1'b1, 4'd6, 32'h0, 4'b0000);
        total++; if (bRd[23:8] !== 16'hFEF0) begin bad++; $display("FAIL be_mid got=%h exp=fef0", bRd[23:8]); end
        total++; if (bRd[31:24] !== 8'h12) begin bad++; $display("FAIL be_top got=%h exp=12", bRd[31:24]); end
    endtask

    task automatic test_read_first();
        opA(1'b1, 1'b0, 1'b0, 10'd7, 8'h12);
        opA(1'b1, 1'b1, 1'b0, 10'd7, 8'h55);
        total++; if (aRd !== 8'h12) begin bad++; $display("FAIL rf_old got=%h exp=12", aRd); end
        total++; if (aRv !== 1'b1) begin bad++; $display("FAIL rf_rvalid got=%0b exp=1", aRv); end
        opA(1'b0, 1'b1, 1'b0, 10'd7, 8'h00);
        total++; if (aRd !== 8'h55) begin bad++; $display("FAIL rf_new got=%h exp=55", aRd); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) opA(1'b1, 1'b0, 1'b0, 10'(200 + i), 8'(8'hA0 + i));
        for (int i = 0; i < 4; i++) begin
            opA(1'b0, 1'b1, 1'b0, 10'(200 + i), 8'h00);
            total++;
            if (aRv !== 1'b1 || aRd !== 8'(8'hA0 + i)) begin
                bad++; $display("FAIL b2b@%0d got=%h/%0b exp=%h/1", 200 + i, aRd, aRv, 8'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_addr_err();
        opC(1'b1, 1'b0, 10'd0, 8'h33);
        opC(1'b1, 1'b0, 10'd999, 8'h77);
        total++; if (cErr !== 1'b0) begin bad++; $display("FAIL err_inrange got=%0b exp=0", cErr); end
        opC(1'b0, 1'b1, 10'd999, 8'h00);
        total++; if (cRd !== 8'h77) begin bad++; $display("FAIL last_word got=%h exp=77", cRd); end
        opC(1'b1, 1'b0, 10'd1000, 8'hEE);
        total++; if (cErr !== 1'b1 || cRv !== 1'b0) begin bad++; $display("FAIL err_write got=%0b/%0b exp=1/0", cErr, cRv); end
        opC(1'b0, 1'b1, 10'd1000, 8'h00);
        total++; if (cErr !== 1'b1 || cRv !== 1'b1) begin bad++; $display("FAIL err_read got=%0b/%0b exp=1/1", cErr, cRv); end
        total++; if (cRd !== 8'h00) begin bad++; $display("FAIL err_rdata got=%h exp=0", cRd); end
        cAddr = 10'd1000;
        @(posedge clk); #1;
        total++; if (cErr !== 1'b0) begin bad++; $display("FAIL err_noreq got=%0b exp=0", cErr); end
        opC(1'b0, 1'b1, 10'd999, 8'h00);
        total++; if (cRd !== 8'h77 || cErr !== 1'b0) begin bad++; $display("FAIL keep999 got=%h/%0b exp=77/0", cRd, cErr); end
        opC(1'b0, 1'b1, 10'd0, 8'h00);
        total++; if (cRd !== 8'h33) begin bad++; $display("FAIL keep0 got=%h exp=33", cRd); end
    endtask

    task automatic test_clear();
`ifdef RAM_CLEAR_EN
        logic [7:0] exp [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
`else
        logic [7:0] exp [4] = '{8'h10, 8'h11, 8'hFF, 8'h13};
`endif
        for (int i = 0; i < 4; i++) opA(1'b1, 1'b0, 1'b0, 10'(i), 8'(8'h10 + i));
        opA(1'b0, 1'b1, 1'b0, 10'd3, 8'h00);
        opA(1'b1, 1'b1, 1'b1, 10'd2, 8'hFF);
`ifdef RAM_CLEAR_EN
        total++; if (aBusy !== 1'b1) begin bad++; $display("FAIL clr_busy got=%0b exp=1", aBusy); end
        total++; if (aRv !== 1'b0 || aRd !== 8'h13) begin bad++; $display("FAIL clr_drop got=%h/%0b exp=13/0", aRd, aRv); end
        repeat (499) @(posedge clk);
        #1;
        total++; if (aBusy !== 1'b1) begin bad++; $display("FAIL clr_midsweep got=%0b exp=1", aBusy); end
`else
        total++; if (aBusy !== 1'b0) begin bad++; $display("FAIL noclr_busy got=%0b exp=0", aBusy); end
        total++; if (aRv !== 1'b1 || aRd !== 8'h12) begin bad++; $display("FAIL noclr_read got=%h/%0b exp=12/1", aRd, aRv); end
`endif
        rst_n = 1'b0;
        #1;
        total++; if (aRd !== 8'h00 || aRv !== 1'b0) begin bad++; $display("FAIL async_rst got=%h/%0b exp=0/0", aRd, aRv); end
        total++; if (aBusy !== EXP_BUSY) begin bad++; $display("FAIL async_rst_busy got=%0b exp=%0b", aBusy, EXP_BUSY); end
        @(posedge clk); #1;
        rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
        countBusy("restart");
`endif
        waitIdle();
        for (int i = 0; i < 4; i++) begin
            opA(1'b0, 1'b1, 1'b0, 10'(i), 8'h00);
            total++; if (aRd !== exp[i]) begin bad++; $display("FAIL post_clr@%0d got=%h exp=%h", i, aRd, exp[i]); end
        end
    endtask

    initial begin
        aAddr = '0; aWd = '0; aBe = '0; aWe = 1'b0; aRe = 1'b0; aClr = 1'b0;
        bAddr = '0; bWd = '0; bBe = '0; bWe = 1'b0; bRe = 1'b0; bClr = 1'b0;
        cAddr = '0; cWd = '0; cBe = '0; cWe = 1'b0; cRe = 1'b0; cClr = 1'b0;
        test_reset();
`ifdef RAM_CLEAR_EN
        test_clear_reads();
`endif
        test_basic();
        test_byte_en();
        test_read_first();
        test_back_to_back();
        test_addr_err();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_sp_be.md
# ram_sp_be

Single-port synchronous RAM, next generation of the 1024 x 8 block: parametrised width and depth, per-byte write enables, registered read with a valid strobe, out-of-range address detection and an optional hardware clear sweep. Sits behind any master that drives a simple Address/WriteEn/ReadEn interface and is a drop-in for the fixed 1024 x 8 RAM when DATA_WIDTH=8, ADDR_WIDTH=10, DEPTH=1024.

## Interface
- DATA_WIDTH, 8: word width in bits; multiple of 8.
- ADDR_WIDTH, 10: address bus width.
- DEPTH, 1024: number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
- clk  in  1  clock; everything sampled on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Address  in  ADDR_WIDTH  word address for read or write.
- WriteData  in  DATA_WIDTH  write data.
- ByteEn  in  DATA_WIDTH/8  per-byte write mask; bit i covers WriteData[8i+7:8i].
- WriteEn  in  1  write request.
- ReadEn  in  1  read request.
- ClearReq  in  1  single-cycle request to zero the whole array.
- ReadData  out  DATA_WIDTH  registered read data.
- ReadValid  out  1  one-cycle strobe: ReadData updated this cycle.
- AddrErr  out  1  one-cycle strobe: previous request had Address >= DEPTH.
- Busy  out  1  clear sweep in progress; requests ignored.

## Operation
- FSM states IDLE and CLEAR. Counter ClrAddr, ADDR_WIDTH bits.
- IDLE: serve requests. WriteEn: for each set ByteEn bit, that byte at Address takes WriteData; clear bits leave byte unchanged; ByteEn all-zero -> no change. ReadEn: ReadData <= mem[Address], ReadValid <= 1.
- WriteEn and ReadEn together, same address: write performed, ReadData returns old (pre-write) contents (read-first).
- Address >= DEPTH: write dropped, read returns 0 with ReadValid=1, AddrErr=1 next cycle. Only when WriteEn or ReadEn is high.
- No read: ReadData holds last value; ReadValid=0.
- ClearReq in IDLE -> CLEAR, ClrAddr=0. ClearReq in the same cycle as WriteEn/ReadEn: clear wins, request dropped, no ReadValid.
- CLEAR: each cycle writes 0 to mem[ClrAddr], ClrAddr+1; after writing DEPTH-1 -> IDLE. WriteEn, ReadEn, ClearReq ignored; ReadValid and AddrErr stay 0; ReadData holds.
- Array contents are not reset by rst_n directly.

## Timing
- Reset values: ReadData=0, ReadValid=0, AddrErr=0, ClrAddr=0; Busy=1 and state CLEAR with RAM_CLEAR_EN, else Busy=0 and state IDLE.
- Read latency 1: ReadEn at edge N -> ReadData/ReadValid valid after edge N, ReadValid low after edge N+1 unless ReadEn again.
- Back-to-back reads/writes every cycle, no bubbles.
- Write at edge N visible to a read sampled at edge N+1.
- Clear sweep: DEPTH cycles with Busy=1; Busy falls after the edge that writes DEPTH-1; first request accepted on the next edge.
- Busy is registered: goes high the cycle after ClearReq is accepted.
- rst_n asserted mid-sweep or mid-access: outputs to reset values immediately; with RAM_CLEAR_EN sweep restarts at address 0 after release.

## Configuration
- RAM_CLEAR_EN defined: CLEAR state, ClrAddr, ClearReq and the post-reset sweep are compiled in; array is all-zero DEPTH cycles after reset release.
- RAM_CLEAR_EN undefined: no CLEAR state; ClearReq ignored; Busy tied 0; block serves requests from the first edge after reset; array contents undefined until written.

## Test plan
- DEPTH=1024, RAM_CLEAR_EN: release reset -> Busy high exactly 1024 cycles, then reads of 0, 131, 1023 return 0 with ReadValid one cycle after ReadEn.
- DATA_WIDTH=8: write 39 @131, 84 @21, 95 @10, then read each -> ReadData 39, 84, 95, one cycle latency, ReadValid pulses.
- DATA_WIDTH=32: write 0xAABBCCDD ByteEn=1111 @5, then 0x11223344 ByteEn=0101 @5, read @5 -> 0xAA22CC44; ByteEn=0000 write -> unchanged.
- Write 0x55 and read simultaneously @7 holding 0x12 -> ReadData 0x12; next read @7 -> 0x55.
- DEPTH=1000: write @1000 then read @1000 -> AddrErr pulses both times, ReadData 0, mem[0..999] unchanged.
- ClearReq after filling @0..3, plus rst_n pulse at sweep cycle 500 -> sweep restarts at 0, Busy high 1024 cycles after release, all reads 0; without RAM_CLEAR_EN ClearReq leaves data intact.
